serial_sub: RTL and testbench

Bit-serial subtractor, the counterpart to the team's bit-serial adder in the same functional datapath library. Loads two unsigned N-bit operands in parallel, then forms A − B one bit per clock, LSB first, through a single borrow flip-flop, and assembles an (N+1)-bit two's-complement difference in a shift register. A level-sensitive start/done handshake sequences each operation.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/serial_sub_if.sv | 21 ++
 rtl/serial_sub_bit_shift_reg.sv | 25 ++
 rtl/serial_sub.sv | 83 ++++++++
 tb/tb_serial_sub.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial arithmetic blocks.
// The serial adder uses the same state encodings and the same default operand width.
package serial_sub_pkg;

  localparam int SERIAL_DEFAULT_N = 8;

  // The encoding 2'b10 is unused. The FSM falls back to IDLE if it ever sees it.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WORK = 2'b01,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle for the bit-serial subtractor.
//   start  : level request (master -> slave)
//   A, B   : unsigned operands, N bits (master -> slave)
//   diff   : N+1-bit two's-complement A - B (slave -> master)
//   busy   : operation in progress (slave -> master)
//   done   : result valid, waiting for start to drop (slave -> master)
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int N = SERIAL_DEFAULT_N
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N:0]   diff;
  logic         busy;
  logic         done;

  modport master (output start, A, B, input diff, busy, done);
  modport slave  (input start, A, B, output diff, busy, done);
endinterface

// File: rtl/serial_sub_bit_shift_reg.sv
// bit_shift_reg: a W-bit right-shift register with a serial-in MSB.
//   clock, resetn : clock and asynchronous active-low reset
//   clr           : synchronous clear (highest priority)
//   load          : parallel load of din
//   en            : shift right one place, with sin entering at the MSB
//   q             : register contents
module bit_shift_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         sin,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= din;
    else if (en)   q <= {sin, q[W-1:1]};
  end
endmodule

// File: rtl/serial_sub.sv
// serial_sub: a bit-serial subtractor that forms A - B one bit per clock, LSB first.
//   clock, resetn : rising-edge clock and asynchronous active-low reset
//   bus           : slave side of serial_sub_if
//                   (start/A/B are inputs; diff/busy/done are outputs)
// The load edge captures A and B. Then N+1 WORK edges run. The last of them
// processes a = b = 0, so diff[N] ends up holding the final borrow, which acts as the sign bit.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = SERIAL_DEFAULT_N
) (
  input  logic      clock,
  input  logic      resetn,
  serial_sub_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  state_e        state;
  logic [CW-1:0] count;
  logic          borrow;
  logic [N-1:0]  a_q, b_q;
  logic [N:0]    diff_q;
  logic          load, work;
  logic          a, b, d, bw_next;

  assign load = (state == IDLE) && bus.start;
  assign work = (state == WORK);

  // full subtractor on the current LSBs
  assign a       = a_q[0];
  assign b       = b_q[0];
  assign d       = a ^ b ^ borrow;
  assign bw_next = (~a & b) | (~(a ^ b) & borrow);

  // Only the LSBs of the operand registers feed the datapath. The upper bits
  // only hold the bits still waiting to be shifted down.
  logic unused_hi;
  assign unused_hi = ^{a_q[N-1:1], b_q[N-1:1]};

  bit_shift_reg #(.W(N)) u_a_reg (
    .clock(clock), .resetn(resetn), .clr(1'b0), .load(load), .en(work),
    .din(bus.A), .sin(1'b0), .q(a_q)
  );

  bit_shift_reg #(.W(N)) u_b_reg (
    .clock(clock), .resetn(resetn), .clr(1'b0), .load(load), .en(work),
    .din(bus.B), .sin(1'b0), .q(b_q)
  );

  // The result register clears on the load edge. Each new difference bit enters at
  // the MSB. After N+1 shifts, bit 0 of the result sits in diff[0].
  bit_shift_reg #(.W(N + 1)) u_diff_reg (
    .clock(clock), .resetn(resetn), .clr(load), .load(1'b0), .en(work),
    .din('0), .sin(d), .q(diff_q)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      count  <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state  <= WORK;
          count  <= '0;
          borrow <= 1'b0;
        end
        WORK: begin
          borrow <= bw_next;
          count  <= count + 1'b1;
          if (count == CW'(N)) state <= DONE;
        end
        DONE: if (!bus.start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.busy = (state == WORK);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and random checks of serial_sub with N=8.
module tb_serial_sub;
  localparam int N = 8;

  logic clock;
  logic resetn;
  int   checks = 0;
  int   passes = 0;

  serial_sub_if #(.N(N)) bus ();

  serial_sub #(.N(N)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one operation, starting and ending at a falling edge. If hold is set,
  // start stays high, and the caller finishes the DONE phase itself.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold,
                        output logic [N:0] d, output int lat, output int bcnt);
    @(negedge clock);
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(negedge clock);                     // just after the load edge
    if (!hold) bus.start = 1'b0;
    lat = 0; bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      @(negedge clock);
      lat++;
    end
    d = bus.diff;
    if (!hold) @(negedge clock);          // DONE edge with start=0 -> IDLE
  endtask

  task automatic test_reset();
    resetn = 1'b0; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    #3;
    checks++;
    if (bus.diff !== 9'h000 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_state got diff=%h busy=%b done=%b exp 000/0/0",
               bus.diff, bus.busy, bus.done);
    else passes++;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_vectors();
    logic [N-1:0] va [5] = '{8'd100, 8'd5, 8'd0,   8'd255, 8'd0};
    logic [N-1:0] vb [5] = '{8'd58,  8'd9, 8'd255, 8'd0,   8'd0};
    logic [N:0]   ve [5] = '{9'h02A, 9'h1FC, 9'h101, 9'h0FF, 9'h000};
    logic [N:0] d; int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 1'b0, d, lat, bcnt);
      checks++;
      if (d !== ve[i]) $display("FAIL vec%0d_diff got %h exp %h", i, d, ve[i]);
      else passes++;
      checks++;
      if (lat !== 9 || bcnt !== 9)
        $display("FAIL vec%0d_latency got lat=%0d busy=%0d exp 9/9", i, lat, bcnt);
      else passes++;
    end
  endtask

  task automatic test_hold_start();
    logic [N:0] d; int lat, bcnt;
    run_op(8'd50, 8'd20, 1'b1, d, lat, bcnt);
    checks++;
    if (d !== 9'h01E) $display("FAIL hold_diff got %h exp 01e", d);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.diff !== 9'h01E)
        $display("FAIL hold_done%0d got done=%b busy=%b diff=%h exp 1/0/01e",
                 i, bus.done, bus.busy, bus.diff);
      else passes++;
    end
    bus.start = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== 9'h01E)
      $display("FAIL hold_release got done=%b busy=%b diff=%h exp 0/0/01e",
               bus.done, bus.busy, bus.diff);
    else passes++;
    run_op(8'd37, 8'd12, 1'b0, d, lat, bcnt);
    checks++;
    if (d !== 9'h019 || lat !== 9) $display("FAIL hold_next got diff=%h lat=%0d exp 019/9", d, lat);
    else passes++;
  endtask

  task automatic test_ignore_inputs();
    int lat;
    @(negedge clock);
    bus.start = 1'b1; bus.A = 8'd77; bus.B = 8'd30;
    @(negedge clock);
    lat = 0;
    while (!bus.done && lat < 40) begin
      bus.A = N'($urandom); bus.B = N'($urandom); bus.start = 1'($urandom);
      @(negedge clock);
      lat++;
    end
    bus.start = 1'b0;
    checks++;
    if (bus.diff !== 9'h02F || lat !== 9)
      $display("FAIL ignore_inputs got diff=%h lat=%0d exp 02f/9", bus.diff, lat);
    else passes++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [N:0] d; int lat, bcnt;
    @(negedge clock);
    bus.start = 1'b1; bus.A = 8'd100; bus.B = 8'd58;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(negedge clock);          // just after WORK edge 4
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 9'h000)
      $display("FAIL reset_mid got busy=%b done=%b diff=%h exp 0/0/000",
               bus.busy, bus.done, bus.diff);
    else passes++;
    #2 resetn = 1'b1;
    run_op(8'd200, 8'd201, 1'b0, d, lat, bcnt);
    checks++;
    if (d !== 9'h1FF || lat !== 9) $display("FAIL reset_after got diff=%h lat=%0d exp 1ff/9", d, lat);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [N:0] d, exp_d; int lat, bcnt;
    logic [N-1:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom); b = N'($urandom);
      exp_d = {1'b0, a} - {1'b0, b};
      run_op(a, b, 1'b0, d, lat, bcnt);
      checks++;
      if (d !== exp_d || lat !== N + 1)
        $display("FAIL sweep%0d a=%0d b=%0d got diff=%h lat=%0d exp %h/%0d",
                 i, a, b, d, lat, exp_d, N + 1);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_hold_start();
    test_ignore_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
